// File: rtl/controlador_corrector_if.sv
// Stream bundle for the Hamming(7,4) correction controller: received-word input
// and corrected-result output, both valid/ready.
interface controlador_corrector_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_palabra;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] out_palabra;
    logic [3:0] out_dato;
    logic       out_error;
    logic [2:0] out_sindrome;

    modport slave (
        input  in_valid, in_palabra, out_ready,
        output in_ready, out_valid, out_palabra, out_dato, out_error, out_sindrome
    );

    modport master (
        output in_valid, in_palabra, out_ready,
        input  in_ready, out_valid, out_palabra, out_dato, out_error, out_sindrome
    );
endinterface

// File: rtl/controlador_corrector.sv
// Hamming(7,4) sequencing controller: FIFO-buffered input, syndrome, external correction,
// registered result. Optional error counter enabled by macro CONT_ERRORES_EN.
module controlador_corrector #(
    parameter int PROFUNDIDAD = 4
`ifdef CONT_ERRORES_EN
    ,
    parameter int ANCHO_CONT  = 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    controlador_corrector_if.slave bus,
    output logic [2:0]            cor_sindrome,
    output logic [6:0]            cor_datos,
    input  logic [6:0]            cor_data,
    output logic                  ocupado
`ifdef CONT_ERRORES_EN
    ,
    output logic [ANCHO_CONT-1:0] cont_errores
`endif
);

    localparam int PTR_W = $clog2(PROFUNDIDAD);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SINDROME = 2'd1,
        CORREGIR = 2'd2,
        SALIDA   = 2'd3
    } estado_t;

    function automatic logic [2:0] calc_sindrome(input logic [6:0] w);
        logic [2:0] s;
        s[0] = w[0] ^ w[2] ^ w[4] ^ w[6];
        s[1] = w[1] ^ w[2] ^ w[5] ^ w[6];
        s[2] = w[3] ^ w[4] ^ w[5] ^ w[6];
        return s;
    endfunction

    estado_t          estado_r, estado_sig_s;
    logic [6:0]       mem_r [PROFUNDIDAD];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] cnt_r, cnt_sig_s;
    logic             in_ready_r, ocupado_r;
    logic             push_s, pop_s, vacio_s, hs_out_s;
    logic [6:0]       trabajo_r;
    logic [2:0]       sind_r;
    logic             out_valid_r, out_error_r;
    logic [6:0]       out_palabra_r;
    logic [3:0]       out_dato_r;
    logic [2:0]       out_sindrome_r;

    assign vacio_s  = (cnt_r == '0);
    assign push_s   = bus.in_valid && in_ready_r;
    assign hs_out_s = out_valid_r && bus.out_ready;

    // Next-state and pop decision; no bypass since pops only see stored words.
    always_comb begin
        estado_sig_s = estado_r;
        pop_s        = 1'b0;
        case (estado_r)
            IDLE: begin
                if (!vacio_s) begin
                    pop_s        = 1'b1;
                    estado_sig_s = SINDROME;
                end else begin
                    estado_sig_s = IDLE;
                end
            end
            SINDROME: estado_sig_s = CORREGIR;
            CORREGIR: estado_sig_s = SALIDA;
            SALIDA: begin
                if (hs_out_s) begin
                    if (!vacio_s) begin
                        pop_s        = 1'b1;
                        estado_sig_s = SINDROME;
                    end else begin
                        estado_sig_s = IDLE;
                    end
                end else begin
                    estado_sig_s = SALIDA;
                end
            end
            default: estado_sig_s = IDLE;
        endcase
    end

    // Occupancy update; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        cnt_sig_s = cnt_r;
        case ({push_s, pop_s})
            2'b10:   cnt_sig_s = cnt_r + CNT_W'(1'b1);
            2'b01:   cnt_sig_s = cnt_r - CNT_W'(1'b1);
            default: cnt_sig_s = cnt_r;
        endcase
    end

    // State register plus FIFO pointers, occupancy and the registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r   <= IDLE;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            cnt_r      <= '0;
            in_ready_r <= 1'b1;
            ocupado_r  <= 1'b0;
        end else begin
            estado_r   <= estado_sig_s;
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            cnt_r      <= cnt_sig_s;
            in_ready_r <= !cnt_sig_s[PTR_W];
            ocupado_r  <= (estado_sig_s != IDLE) || (cnt_sig_s != '0);
        end
    end

    // FIFO storage; contents are only meaningful under the occupancy count.
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= bus.in_palabra;
    end

    // Work word, syndrome and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            trabajo_r      <= 7'd0;
            sind_r         <= 3'd0;
            out_valid_r    <= 1'b0;
            out_palabra_r  <= 7'd0;
            out_dato_r     <= 4'd0;
            out_error_r    <= 1'b0;
            out_sindrome_r <= 3'd0;
        end else begin
            if (pop_s) trabajo_r <= mem_r[rd_ptr_r];
            if (estado_r == SINDROME) sind_r <= calc_sindrome(trabajo_r);
            if (estado_r == CORREGIR) begin
                out_palabra_r  <= cor_data;
                out_dato_r     <= {cor_data[6], cor_data[5], cor_data[4], cor_data[2]};
                out_error_r    <= (sind_r != 3'd0);
                out_sindrome_r <= sind_r;
            end
            out_valid_r <= (estado_sig_s == SALIDA);
        end
    end

`ifdef CONT_ERRORES_EN
    logic [ANCHO_CONT-1:0] cont_r;

    // Saturating count of corrected results actually delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            cont_r <= '0;
        end else if (hs_out_s && out_error_r && (cont_r != '1)) begin
            cont_r <= cont_r + ANCHO_CONT'(1'b1);
        end else begin
            cont_r <= cont_r;
        end
    end

    assign cont_errores = cont_r;
`endif

    assign bus.in_ready     = in_ready_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_palabra  = out_palabra_r;
    assign bus.out_dato     = out_dato_r;
    assign bus.out_error    = out_error_r;
    assign bus.out_sindrome = out_sindrome_r;
    assign cor_datos        = trabajo_r;
    assign cor_sindrome     = sind_r;
    assign ocupado          = ocupado_r;

endmodule

// File: doc/controlador_corrector.md
Name: controlador_corrector

Overview:
- Sequencing controller for the Hamming(7,4) error-correction path.
- Accepts received 7-bit codewords through a valid/ready input, buffers them in a small FIFO, and computes the 3-bit syndrome for each.
- Drives the external combinational corrector with the word and its syndrome, registers the corrected word, and presents it on a valid/ready output with the decoded 4-bit datum and an error flag.

Parameters:
PROFUNDIDAD, 4, input FIFO depth in words; power of 2, minimum 2.
ANCHO_CONT, 8, width of the error counter (optional feature only).

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  in_palabra holds a valid codeword.
in_ready  output  1  FIFO can accept a word; equals FIFO not full.
in_palabra  input  7  received codeword [i3,i2,i1,c2,i0,c1,c0].
cor_sindrome  output  3  syndrome [p2,p1,p0] to the corrector.
cor_datos  output  7  working codeword to the corrector.
cor_data  input  7  corrected word returned combinationally by the corrector.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts the result.
out_palabra  output  7  corrected codeword.
out_dato  output  4  decoded data {i3,i2,i1,i0} = out_palabra bits {6,5,4,2}.
out_error  output  1  1 when the syndrome was nonzero (single-bit correction applied).
out_sindrome  output  3  syndrome of this result.
ocupado  output  1  high whenever state is not IDLE or the FIFO is not empty.

Behaviour:
- Reset (rst=1 at clk edge):
  - FIFO is emptied; state goes to IDLE.
  - Work register, result registers and outputs are cleared to 0: out_valid, out_palabra, out_dato, out_error, out_sindrome, cor_sindrome, cor_datos.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards buffered words and any pending result.
- Input handshake:
  - A push occurs on an edge where in_valid && in_ready.
  - While full, in_ready=0 and in_palabra is ignored.
  - No bypass: a word pushed into an empty FIFO is not popped on the same edge.
- Syndrome definition:
  - p0 = d0^d2^d4^d6; p1 = d1^d2^d5^d6; p2 = d3^d4^d5^d6.
  - 000 means no error; a nonzero value is the 1-based position of the faulty bit.
- State machine:
  - IDLE: if FIFO not empty, pop into the work register and go to SINDROME; otherwise stay.
  - SINDROME: register the syndrome of the work word; go to CORREGIR.
  - CORREGIR: cor_datos = work word and cor_sindrome = registered syndrome, held steady for the whole state. Capture cor_data into out_palabra, derive out_dato, set out_error = (syndrome != 0), copy out_sindrome. Go to SALIDA.
  - SALIDA: out_valid=1, outputs held stable until out_ready.
    - On handshake with FIFO not empty: pop the next word, go to SINDROME.
    - On handshake with FIFO empty: go to IDLE.
    - No handshake: stay.
- Timing:
  - Latency: a word pushed at edge N into an idle, empty block gives out_valid=1 after edge N+3.
  - Sustained throughput: one word per 3 cycles when out_ready is held at 1.
  - out_valid is low in every state except SALIDA.
- FIFO pointers are log2(PROFUNDIDAD) bits and wrap modulo depth. Full/empty are distinguished by an occupancy counter of width log2(PROFUNDIDAD)+1.
- Simultaneous push and pop on one edge: the count is unchanged and both pointers advance.

Optional Feature:
Macro: CONT_ERRORES_EN.
- Defined:
  - Adds output cont_errores [ANCHO_CONT-1:0].
  - The counter increments by 1 on each output handshake where out_error=1.
  - It saturates at all-ones and clears on rst.
- Undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
1. Clean word: rst for 2 cycles, then push 0x55 with out_ready=1 → out_valid 3 cycles after the push; out_palabra=0x55, out_dato=0xB, out_error=0, out_sindrome=0.
2. Single-bit error: push 0x45 (bit 4 flipped) → cor_sindrome=3'b101 during CORREGIR; out_palabra=0x55, out_dato=0xB, out_error=1, out_sindrome=5.
3. Backpressure/full: out_ready=0, push PROFUNDIDAD+1 words → in_ready drops after PROFUNDIDAD+1 accepted (FIFO full with one word in work). With out_ready=1, all words come out in order with outputs stable while stalled.
4. Wrap-around: stream 10 words (error in each position 1–7, then 3 clean) with out_ready=1 → correct results in order, one result per 3 cycles, no loss across pointer wrap.
5. Reset mid-operation: assert rst during SALIDA with 2 words buffered → next cycle out_valid=0, in_ready=1, ocupado=0. No stale result appears afterwards.
6. (CONT_ERRORES_EN) Push 3 erroneous and 2 clean words → cont_errores=3. With ANCHO_CONT=2, push 5 erroneous words → counter saturates at 3.
